costas_phase_detector: RTL

- Closes the Costas carrier loop. Mixes the 1-bit IF sample stream with the 1-bit sine/cosine replicas from the NCO.
- Integrates I and Q over fixed blocks and forms a Costas discriminator.
- Filters the discriminator into a modular phase accumulator. The top 2 bits drive the NCO `phase_error` input.
- Sits between the RF front-end sign bit and the NCO in the carrier-tracking path.

---
 rtl/costas_pkg.sv | 22 ++
 rtl/costas_loop_filter.sv | 77 +++++++
 rtl/costas_phase_detector.sv | 111 +++++++++++
 3 files changed

// File: rtl/costas_pkg.sv
// Purpose: shared types, defaults and helpers for the Costas carrier phase detector.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package costas_pkg;

   localparam int INT_LEN_DEF = 16;
   localparam int ACC_W_DEF   = 8;

   // 2-bit phase offset handed to the NCO, modulo-4 arithmetic
   typedef logic [1:0] phase_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Maps a 1-bit agreement flag to +1 (agree) / -1 (disagree)
   function automatic logic signed [1:0] bit_to_pm1(input logic b);
      return b ? 2'sb01 : 2'sb11;
   endfunction

endpackage

// File: rtl/costas_loop_filter.sv
// Purpose: Costas discriminator, loop gain shift, modular phase accumulator and lock counter.
// Latency: 1 clk from in_vld to updated phase_error / dumps / dump_valid / lock.
// Backpressure: none; every in_vld pulse is consumed in the cycle it arrives.
// Ports: clk, rst (async active-low); in_vld/in_i/in_q = block sums from the integrators;
//        phase_error, i_dump, q_dump, dump_valid, lock = registered results.
module costas_loop_filter
   import costas_pkg::*;
#(
   parameter int SUM_W      = 6,
   parameter int ACC_W      = ACC_W_DEF,
   parameter int GAIN_SHIFT = 2,
   parameter int LOCK_CNT   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_vld,
   input  logic signed [SUM_W-1:0] in_i,
   input  logic signed [SUM_W-1:0] in_q,
   output phase_t                  phase_error,
   output logic signed [SUM_W-1:0] i_dump,
   output logic signed [SUM_W-1:0] q_dump,
   output logic                    dump_valid,
   output logic                    lock
);

   localparam int EXT_W = ACC_W + SUM_W;
   localparam int LK_W  = $clog2(LOCK_CNT + 1);

   logic        [ACC_W-1:0] acc;
   logic        [ACC_W-1:0] acc_nxt;
   logic signed [SUM_W-1:0] d;
   logic signed [EXT_W-1:0] d_ext;
   logic        [ACC_W-1:0] d_sh;
   logic        [SUM_W-1:0] abs_i;
   logic        [SUM_W-1:0] abs_q;
   logic        [LK_W-1:0]  lk_cnt;
   logic        [LK_W-1:0]  lk_nxt;

   always_comb begin
      // I == 0 is treated as the positive half-plane
      d      = in_i[SUM_W-1] ? -in_q : in_q;
      d_ext  = {{ACC_W{d[SUM_W-1]}}, d};
      // arithmetic shift on the widened value, then wrap into the accumulator width
      d_sh    = ACC_W'(d_ext >>> GAIN_SHIFT);
      acc_nxt = acc + d_sh;
      // magnitudes fit unsigned: sums never exceed +/-INT_LEN
      abs_i  = in_i[SUM_W-1] ? -in_i : in_i;
      abs_q  = in_q[SUM_W-1] ? -in_q : in_q;
      if (abs_i > abs_q)
         lk_nxt = (lk_cnt == LK_W'(LOCK_CNT)) ? lk_cnt : lk_cnt + 1'b1;
      else
         lk_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc         <= '0;
         phase_error <= 2'b00;
         i_dump      <= '0;
         q_dump      <= '0;
         dump_valid  <= 1'b0;
         lk_cnt      <= '0;
         lock        <= 1'b0;
      end else begin
         dump_valid <= in_vld;
         if (in_vld) begin
            acc         <= acc_nxt;
            phase_error <= acc_nxt[ACC_W-1 -: 2];
            i_dump      <= in_i;
            q_dump      <= in_q;
            lk_cnt      <= lk_nxt;
            lock        <= (lk_nxt == LK_W'(LOCK_CNT));
         end
      end
   end

endmodule

// File: rtl/costas_phase_detector.sv
// Purpose: Costas carrier phase detector: 1-bit mixing, I/Q integrate-and-dump, loop filter to NCO.
// Latency: last sample of a block -> phase_error / i_dump / q_dump / dump_valid after 2 clk edges.
// Backpressure: none; one sample per clk while en=1, dropping en abandons the partial block.
// Ports: clk, rst (async active-low), en, sample, sine, cosine in;
//        phase_error, i_dump, q_dump, dump_valid, lock out.
module costas_phase_detector
   import costas_pkg::*;
#(
   parameter int INT_LEN    = INT_LEN_DEF,
   parameter int SUM_W      = $clog2(INT_LEN) + 2,
   parameter int ACC_W      = ACC_W_DEF,
   parameter int GAIN_SHIFT = 2,
   parameter int LOCK_CNT   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    sample,
   input  logic                    sine,
   input  logic                    cosine,
   output phase_t                  phase_error,
   output logic signed [SUM_W-1:0] i_dump,
   output logic signed [SUM_W-1:0] q_dump,
   output logic                    dump_valid,
   output logic                    lock
);

   localparam int CNT_W = $clog2(INT_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(INT_LEN - 1);

   state_t                  state;
   logic        [CNT_W-1:0] cnt;
   logic signed [SUM_W-1:0] i_sum;
   logic signed [SUM_W-1:0] q_sum;
   logic signed [SUM_W-1:0] i_base;
   logic signed [SUM_W-1:0] q_base;
   logic        [CNT_W-1:0] cnt_base;
   logic signed [1:0]       i_pm;
   logic signed [1:0]       q_pm;
   logic signed [SUM_W-1:0] i_new;
   logic signed [SUM_W-1:0] q_new;
   logic signed [SUM_W-1:0] s1_i;
   logic signed [SUM_W-1:0] s1_q;
   logic                    s1_vld;

   always_comb begin
      i_pm     = bit_to_pm1(sample ~^ cosine);
      q_pm     = bit_to_pm1(sample ~^ sine);
      // A block always starts from zero when entering from IDLE, so the sample
      // presented on the enabling edge is the first sample of the block.
      i_base   = (state == RUN) ? i_sum : '0;
      q_base   = (state == RUN) ? q_sum : '0;
      cnt_base = (state == RUN) ? cnt   : '0;
      i_new    = i_base + {{(SUM_W-2){i_pm[1]}}, i_pm};
      q_new    = q_base + {{(SUM_W-2){q_pm[1]}}, q_pm};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         i_sum  <= '0;
         q_sum  <= '0;
         s1_i   <= '0;
         s1_q   <= '0;
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= 1'b0;
         if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            i_sum <= '0;
            q_sum <= '0;
         end else begin
            state <= RUN;
            if (cnt_base == LAST) begin
               // final sums include this sample; next sample opens a new block
               s1_i   <= i_new;
               s1_q   <= q_new;
               s1_vld <= 1'b1;
               cnt    <= '0;
               i_sum  <= '0;
               q_sum  <= '0;
            end else begin
               cnt   <= cnt_base + 1'b1;
               i_sum <= i_new;
               q_sum <= q_new;
            end
         end
      end
   end

   costas_loop_filter #(
      .SUM_W      (SUM_W),
      .ACC_W      (ACC_W),
      .GAIN_SHIFT (GAIN_SHIFT),
      .LOCK_CNT   (LOCK_CNT)
   ) u_filter (
      .clk         (clk),
      .rst         (rst),
      .in_vld      (s1_vld),
      .in_i        (s1_i),
      .in_q        (s1_q),
      .phase_error (phase_error),
      .i_dump      (i_dump),
      .q_dump      (q_dump),
      .dump_valid  (dump_valid),
      .lock        (lock)
   );

endmodule
